layer_2_input_packer: RTL and testbench
=======================================

# layer_2_input_packer

Channel-serial to channel-parallel packer feeding the layer-2 feature-map stage. It accepts one 32-bit float per cycle, channel 0 first, from the layer-1 output path. It assembles each pixel's 16 channels into one 512-bit beat, matching the lane order the layer-2 Conv2D3x3 bank consumes (channel k on bits [32k+31:32k]). It also tracks pixel position in the IMG_SIZE×IMG_SIZE frame and flags the last beat.

## Interface
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single)
- NUM_CHANNELS, 16, channels per pixel; output width is DATA_WIDTH*NUM_CHANNELS = 512
- IMG_SIZE, 208, frame height and width in pixels
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-low
- data_in  in  DATA_WIDTH  one channel sample
- valid_in  in  1  data_in valid
- ready_out  out  1  packer accepts data_in this cycle
- data_out  out  DATA_WIDTH*NUM_CHANNELS  packed pixel, lane k = channel k
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream accepts data_out; tie high when driving the feature-map stage directly
- last_out  out  1  qualifies valid_out; high on the beat of pixel IMG_SIZE*IMG_SIZE-1

## Operation
- Input transfer: valid_in && ready_out. Output transfer: valid_out && ready_in.
- Assembly register asm (512 b), lane counter lane (0..NUM_CHANNELS-1), flag asm_full.
- Assembly FSM:
  - FILL: on each input transfer, write data_in into lane `lane`, then lane++.
  - On the transfer at lane = NUM_CHANNELS-1, lane wraps to 0 and the pixel is complete.
  - Complete pixel with output slot free: the pixel moves straight to the output register.
  - Complete pixel with output slot occupied: go to FULL (asm_full=1).
  - FULL: ready_out=0. Leave FULL in the cycle the output register drains; asm moves to the output register and the FSM returns to FILL.
- Output slot free means: valid_out=0, or an output transfer happens in the same cycle.
- ready_out = !asm_full (combinational from a register only; no path from valid_in).
- Output register: valid_out, data_out and last_out are held stable while valid_out && !ready_in.
- Pixel counter pix (0..IMG_SIZE²-1):
  - Increments when a pixel is loaded into the output register.
  - last_out = (pix == IMG_SIZE²-1) at load time; pix then wraps to 0.
- Counter widths: lane uses $clog2(NUM_CHANNELS) bits; pix uses $clog2(IMG_SIZE*IMG_SIZE) bits (16 for 208). No saturation, explicit wrap compare.
- No float arithmetic; data is passed bit-exact.

## Timing
- Reset (Rst=0, async): valid_out=0, last_out=0, data_out=0, ready_out=1, lane=0, pix=0, asm_full=0. Asm contents are don't-care.
- Reset mid-pixel or mid-frame discards the partial pixel and any held beat. The first sample after release is channel 0 of pixel 0.
- Latency: input transfer of lane 15 at edge N produces valid_out=1 after edge N, visible in cycle N+1, when the output slot is free.
- Throughput: one beat per NUM_CHANNELS input transfers. Sustained ready_in=1 never deasserts ready_out.
- Backpressure: if ready_in stays low for 16 or more input transfers after a beat is presented, the next complete pixel waits in asm and ready_out drops the cycle after it completes. Total buffering is 2 pixels.
- Simultaneous complete-pixel and output drain: handoff occurs in that cycle and ready_out stays 1.
- valid_in gaps are allowed at any lane; the lane position is retained.
- data_in and valid_in are ignored while ready_out=0.

## Structure
- Shared package layer_pkg:
  - DATA_WIDTH, NUM_CHANNELS, IMG_SIZE defaults
  - derived LANE_W, PIX_W, BUS_W
  - an enum for the FILL/FULL states
- One sub-module, stream_out_reg: a valid/ready register stage holding {last, data}, with load/drain logic. It is reusable by other layer packers.

## Test plan
- Reset then feed lanes 0..15 = 32'h3f800000+k back-to-back with ready_in=1 -> one beat in cycle 17 with lane k = 32'h3f800000+k, valid_out for exactly 1 cycle, last_out=0.
- Assert Rst low at lane 7 of a pixel, release, then feed 16 samples -> the beat contains only post-reset samples and pix restarts at 0.
- Hold ready_in=0 and stream 3 pixels:
  - beat 1 is held stable;
  - ready_out drops after pixel 2 completes and pixel 3 is refused;
  - raising ready_in releases beats 1 and 2 in order, with no data loss.
- Full 208×208 frame with random valid_in gaps -> 43264 beats, last_out only on beat 43264, and the next frame's first beat has last_out=0.
- Complete lane 15 in the same cycle as ready_in rises with asm needed -> no ready_out bubble and the beat follows immediately.
- IMG_SIZE=2, NUM_CHANNELS=4 override -> last_out on every 4th beat; pix wraps correctly.

Source files
------------

// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_pkg
// Purpose  : Shared sizing defaults, derived widths and FSM states for packers
// Revision : 1.0
// ============================================================================
package layer_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_CHANNELS = 16;
  localparam int DEF_IMG_SIZE     = 208;

  // Widths of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int count_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = count_bits(DEF_NUM_CHANNELS);
  localparam int PIX_W  = count_bits(DEF_IMG_SIZE * DEF_IMG_SIZE);
  localparam int BUS_W  = DEF_DATA_WIDTH * DEF_NUM_CHANNELS;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } asm_state_e;

endpackage : layer_pkg
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : stream_out_reg
// Purpose  : Single-entry valid/ready output register; loads when empty or
//            draining, holds its word stable under backpressure.
// Revision : 1.0
// ============================================================================
module stream_out_reg
  import layer_pkg::*;
#(
  parameter int WIDTH = BUS_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             load;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : stream_out_reg
`default_nettype wire

// File: rtl/layer_2_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : layer_2_input_packer
// Purpose  : Packs NUM_CHANNELS serial samples into one parallel pixel beat,
//            tracks frame position and flags the final pixel of each frame.
// Revision : 1.0
// ============================================================================
module layer_2_input_packer
  import layer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int IMG_SIZE     = DEF_IMG_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               valid_in,
  output logic                               ready_out,
  output logic [DATA_WIDTH*NUM_CHANNELS-1:0] data_out,
  output logic                               valid_out,
  input  logic                               ready_in,
  output logic                               last_out
);

  localparam int LANE_BITS = count_bits(NUM_CHANNELS);
  localparam int PIX_BITS  = count_bits(IMG_SIZE * IMG_SIZE);
  localparam int BUS_BITS  = DATA_WIDTH * NUM_CHANNELS;

  localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(NUM_CHANNELS - 1);
  localparam logic [PIX_BITS-1:0]  PIX_LAST  = PIX_BITS'(IMG_SIZE * IMG_SIZE - 1);

  asm_state_e           state_q, state_d;
  logic [LANE_BITS-1:0] lane_q,  lane_d;
  logic [PIX_BITS-1:0]  pix_q,   pix_d;
  logic [BUS_BITS-1:0]  asm_q,   asm_d;

  logic                in_xfer;
  logic                pixel_done;
  logic [BUS_BITS-1:0] pixel_word;
  logic                slot_free;
  logic                load_valid;
  logic [BUS_BITS-1:0] load_data;
  logic                load_last;
  logic                load;
  logic [BUS_BITS:0]   out_word;

  assign ready_out  = (state_q == ST_FILL);
  assign in_xfer    = valid_in && ready_out;
  assign pixel_done = in_xfer && (lane_q == LANE_LAST);

  // Assembly contents with the current sample merged in, so a completing
  // pixel can bypass asm and go straight to the output register.
  always_comb begin
    pixel_word = asm_q;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (lane_q == LANE_BITS'(k)) begin
        pixel_word[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
    end
  end

  assign load_valid = (state_q == ST_FULL) || pixel_done;
  assign load_data  = (state_q == ST_FULL) ? asm_q : pixel_word;
  assign load_last  = (pix_q == PIX_LAST);
  assign load       = load_valid && slot_free;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    pix_d   = pix_q;

    if (in_xfer) begin
      asm_d  = pixel_word;
      lane_d = pixel_done ? '0 : lane_q + LANE_BITS'(1);
    end

    if (load) begin
      pix_d = load_last ? '0 : pix_q + PIX_BITS'(1);
    end

    case (state_q)
      ST_FILL: if (pixel_done && !slot_free) state_d = ST_FULL;
      ST_FULL: if (slot_free)                state_d = ST_FILL;
      default:                               state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      lane_q  <= '0;
      pix_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pix_q   <= pix_d;
      asm_q   <= asm_d;
    end
  end

  stream_out_reg #(
    .WIDTH (BUS_BITS + 1)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (load_valid),
    .in_data   ({load_last, load_data}),
    .in_ready  (slot_free),
    .out_valid (valid_out),
    .out_data  (out_word),
    .out_ready (ready_in)
  );

  assign data_out = out_word[BUS_BITS-1:0];
  assign last_out = out_word[BUS_BITS];

endmodule : layer_2_input_packer
`default_nettype wire

// File: tb/tb_layer_2_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_2_input_packer
// Purpose  : Scoreboard bench for the packer at default size and at a small
//            4-channel 2x2 frame.
// Revision : 1.0
// ============================================================================
module tb_layer_2_input_packer;

  localparam int NCH     = 16;
  localparam int FRAME   = 208 * 208;
  localparam int NCH_S   = 4;
  localparam int FRAME_S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  data_in;
  logic         valid_in;
  logic         ready_out;
  logic [511:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic         last_out;

  logic [31:0]  data_in_s;
  logic         valid_in_s;
  logic         ready_out_s;
  logic [127:0] data_out_s;
  logic         valid_out_s;
  logic         ready_in_s;
  logic         last_out_s;

  layer_2_input_packer dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .last_out(last_out)
  );

  layer_2_input_packer #(.DATA_WIDTH(32), .NUM_CHANNELS(NCH_S), .IMG_SIZE(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .data_in(data_in_s), .valid_in(valid_in_s),
    .ready_out(ready_out_s), .data_out(data_out_s), .valid_out(valid_out_s),
    .ready_in(ready_in_s), .last_out(last_out_s)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: samples gathered per pixel, complete pixels queued
  logic [31:0]  part0[$], part1[$];
  logic [511:0] expd0[$], expd1[$];
  bit           expl0[$], expl1[$];
  int           pix0 = 0, pix1 = 0;
  bit           stop_rdy0, stop_rdy1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  always @(negedge clk) begin : mon_main
    logic [511:0] w;
    if (rst_n === 1'b1) begin
      check("ready_out", {511'b0, ready_out}, {511'b0, expd0.size() < 2});
      check("valid_out", {511'b0, valid_out}, {511'b0, expd0.size() != 0});
      if (valid_out && expd0.size() != 0) begin
        check("data_out", data_out, expd0[0]);
        check("last_out", {511'b0, last_out}, {511'b0, expl0[0]});
        if (ready_in) begin
          void'(expd0.pop_front());
          void'(expl0.pop_front());
        end
      end
      if (valid_in && ready_out) begin
        part0.push_back(data_in);
        if (part0.size() == NCH) begin
          w = '0;
          for (int k = 0; k < NCH; k++) w[32*k +: 32] = part0[k];
          expd0.push_back(w);
          expl0.push_back(pix0 == FRAME - 1);
          pix0 = (pix0 + 1) % FRAME;
          part0.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : mon_small
    logic [511:0] w;
    if (rst_n === 1'b1) begin
      check("s_ready_out", {511'b0, ready_out_s}, {511'b0, expd1.size() < 2});
      check("s_valid_out", {511'b0, valid_out_s}, {511'b0, expd1.size() != 0});
      if (valid_out_s && expd1.size() != 0) begin
        check("s_data_out", {384'b0, data_out_s}, expd1[0]);
        check("s_last_out", {511'b0, last_out_s}, {511'b0, expl1[0]});
        if (ready_in_s) begin
          void'(expd1.pop_front());
          void'(expl1.pop_front());
        end
      end
      if (valid_in_s && ready_out_s) begin
        part1.push_back(data_in_s);
        if (part1.size() == NCH_S) begin
          w = '0;
          for (int k = 0; k < NCH_S; k++) w[32*k +: 32] = part1[k];
          expd1.push_back(w);
          expl1.push_back(pix1 == FRAME_S - 1);
          pix1 = (pix1 + 1) % FRAME_S;
          part1.delete();
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] d);
    int n = 0;
    bit acc;
    data_in  = d;
    valid_in = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) timeout_fail("send0");
    valid_in = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d);
    int n = 0;
    bit acc;
    data_in_s  = d;
    valid_in_s = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_out_s;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) timeout_fail("send1");
    valid_in_s = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid_out", {511'b0, valid_out}, 512'd0);
    check("rst_last_out",  {511'b0, last_out},  512'd0);
    check("rst_data_out",  data_out,            512'd0);
    check("rst_ready_out", {511'b0, ready_out}, 512'd1);
    check("rst_s_ready",   {511'b0, ready_out_s}, 512'd1);
    part0.delete(); expd0.delete(); expl0.delete(); pix0 = 0;
    part1.delete(); expd1.delete(); expl1.delete(); pix1 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain0();
    int n = 0;
    ready_in = 1'b1;
    while (expd0.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (expd0.size() != 0) timeout_fail("drain0");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n      = 1'b0;
    data_in    = '0; valid_in   = 1'b0; ready_in   = 1'b1;
    data_in_s  = '0; valid_in_s = 1'b0; ready_in_s = 1'b1;
    idle(2);
    do_reset();

    // Back-to-back pixel of 1.0f + k, beat expected right after lane 15
    for (int k = 0; k < NCH; k++) send0(32'h3f800000 + k);
    check("latency_valid", {511'b0, valid_out}, 512'd1);
    check("lane5", {480'b0, data_out[5*32 +: 32]}, {480'b0, 32'h3f800005});
    idle(3);

    // Held beat plus partial pixel discarded by reset mid-pixel
    ready_in = 1'b0;
    for (int k = 0; k < NCH; k++) send0($urandom);
    for (int k = 0; k < 7; k++) send0($urandom);
    do_reset();
    ready_in = 1'b1;
    for (int k = 0; k < NCH; k++) send0(32'hc0000000 + k);
    idle(3);

    // Three pixels under sustained backpressure
    ready_in = 1'b0;
    fork
      for (int k = 0; k < 3 * NCH; k++) send0($urandom);
      begin
        idle(50);
        #2;
        check("bp_refused", {511'b0, ready_out}, 512'd0);
        idle(20);
        ready_in = 1'b1;
      end
    join
    drain0();

    // Lane 15 completes in the same cycle ready_in rises
    ready_in = 1'b0;
    for (int k = 0; k < NCH; k++) send0($urandom);
    for (int k = 0; k < NCH - 1; k++) send0($urandom);
    ready_in = 1'b1;
    send0($urandom);
    check("handoff_ready", {511'b0, ready_out}, 512'd1);
    for (int k = 0; k < NCH; k++) send0($urandom);
    drain0();

    // Random valid gaps and random backpressure
    stop_rdy0 = 1'b0;
    fork
      begin
        for (int p = 0; p < 30 * NCH; p++) begin
          if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
          send0($urandom);
        end
        stop_rdy0 = 1'b1;
      end
      while (!stop_rdy0) begin
        ready_in = ($urandom_range(2) != 0);
        idle(1);
      end
    join
    drain0();

    // Small instance: three frames plus one pixel of the next frame
    stop_rdy1 = 1'b0;
    fork
      begin
        for (int p = 0; p < (3 * FRAME_S + 1) * NCH_S; p++) begin
          if ($urandom_range(2) == 0) idle($urandom_range(1, 4));
          send1($urandom);
        end
        stop_rdy1 = 1'b1;
      end
      while (!stop_rdy1) begin
        ready_in_s = ($urandom_range(2) != 0);
        idle(1);
      end
    join
    ready_in_s = 1'b1;
    begin
      int n = 0;
      while (expd1.size() != 0 && n < 200) begin
        idle(1);
        n++;
      end
      if (expd1.size() != 0) timeout_fail("drain1");
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_layer_2_input_packer
`default_nettype wire
